param_prescaler: RTL and testbench

//  Programmable clock-enable generator that sits directly upstream of param_counter.

---
 rtl/param_prescaler.sv | 134 +++++++++++++
 tb/tb_param_prescaler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_prescaler.sv
// Programmable clock-enable generator: divides clk by a loadable ratio, continuous or fixed-length burst, registered outputs.
// Optional running tick counter on output tick_total when PARAM_PRESCALER_TICK_COUNT_EN is defined.
module param_prescaler #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1000,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DIV_W-1:0]   div_in,
  input  logic               div_valid,
  output logic               div_ready,
  output logic               tick,
  output logic               busy,
  output logic               done
`ifdef PARAM_PRESCALER_TICK_COUNT_EN
  ,
  output logic [31:0]        tick_total
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [DIV_W-1:0]   D_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DEF_Q   = DIV_W'(DEF_DIV);
  localparam logic [BURST_W:0]   B_ONE   = (BURST_W+1)'(1);

  state_t             state_q;
  logic [DIV_W-1:0]   div_q, shadow_q, pre_q;
  logic               shadow_vld_q, rdy_q;
  logic               mode_q;
  logic [BURST_W:0]   burst_q, len_q;
  logic               tick_q, busy_q, done_q, fin_q;

  logic               xfer_d, launch_d, active_d, wrap_d, final_d, run_on_d, going_idle_d;
  logic               mode_d;
  logic [DIV_W-1:0]   div_fix_d;
  logic [BURST_W:0]   len_in_d, len_d, burst_d, burst_inc_d;

  // IDLE keeps pre_q at zero, so the launch edge counts as prescale step zero.
  always_comb begin
    xfer_d       = div_valid && rdy_q;
    div_fix_d    = (div_in == '0) ? D_ONE : div_in;
    len_in_d     = {(burst_len == '0), burst_len};
    launch_d     = (state_q == S_IDLE) && start && !stop;
    active_d     = launch_d || ((state_q == S_RUN) && !stop);
    wrap_d       = (pre_q == (div_q - D_ONE));
    mode_d       = launch_d ? mode : mode_q;
    len_d        = launch_d ? len_in_d : len_q;
    burst_d      = launch_d ? '0 : burst_q;
    burst_inc_d  = burst_d + B_ONE;
    final_d      = active_d && wrap_d && mode_d && (burst_inc_d == len_d);
    run_on_d     = active_d && !final_d;
    going_idle_d = (state_q == S_RUN) && !run_on_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= DEF_Q;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      rdy_q        <= 1'b1;
      pre_q        <= '0;
      mode_q       <= 1'b0;
      burst_q      <= '0;
      len_q        <= '0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      tick_q <= active_d && wrap_d;
      fin_q  <= final_d;
      done_q <= fin_q;

      if (run_on_d) begin
        state_q <= S_RUN;
        busy_q  <= 1'b1;
        pre_q   <= wrap_d ? '0 : (pre_q + D_ONE);
        burst_q <= (wrap_d && mode_d) ? burst_inc_d : burst_d;
      end else begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        pre_q   <= '0;
        burst_q <= '0;
      end

      if (launch_d) begin
        mode_q <= mode;
        len_q  <= len_in_d;
      end

      // While running, a new divisor waits in the shadow until the period boundary.
      if (state_q == S_IDLE) begin
        if (xfer_d) div_q <= div_fix_d;
      end else if (going_idle_d) begin
        if (xfer_d)            div_q <= div_fix_d;
        else if (shadow_vld_q) div_q <= shadow_q;
        shadow_vld_q <= 1'b0;
        rdy_q        <= 1'b1;
      end else if (wrap_d && shadow_vld_q) begin
        div_q        <= shadow_q;
        shadow_vld_q <= 1'b0;
        rdy_q        <= 1'b1;
      end else if (xfer_d) begin
        shadow_q     <= div_fix_d;
        shadow_vld_q <= 1'b1;
        rdy_q        <= 1'b0;
      end
    end
  end

  assign div_ready = rdy_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef PARAM_PRESCALER_TICK_COUNT_EN
  logic [31:0] total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    total_q <= '0;
    else if (active_d && wrap_d) total_q <= total_q + 32'd1;
  end

  assign tick_total = total_q;
`endif

endmodule

// File: tb/tb_param_prescaler.sv
// Directed bench for param_prescaler: expected tick cycles queued at stimulus, compared as ticks appear.
module tb_param_prescaler;

  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 1000;
  localparam int BURST_W = 4;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic               mode;
  logic [BURST_W-1:0] burst_len;
  logic [DIV_W-1:0]   div_in;
  logic               div_valid;
  logic               div_ready;
  logic               tick;
  logic               busy;
  logic               done;
`ifdef PARAM_PRESCALER_TICK_COUNT_EN
  logic [31:0]        tick_total;
`endif

  param_prescaler #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .burst_len (burst_len),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
`ifdef PARAM_PRESCALER_TICK_COUNT_EN
    ,
    .tick_total(tick_total)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; cyc numbers the cycle just entered.
  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    logic exp_t;
    for (int i = 0; i < n; i++) begin
      tick_clk();
      start     = 1'b0;
      stop      = 1'b0;
      div_valid = 1'b0;
      exp_t = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (exp_t) void'(exp_q.pop_front());
      chk($sformatf("tick@%0d", cyc), {31'd0, tick}, {31'd0, exp_t});
    end
  endtask

  task automatic load_div(input logic [DIV_W-1:0] v);
    div_in    = v;
    div_valid = 1'b1;
    tick_clk();
    div_valid = 1'b0;
  endtask

  task automatic start_pulse(input logic m, input logic [BURST_W-1:0] len);
    mode      = m;
    burst_len = len;
    start     = 1'b1;
    cyc       = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    burst_len = '0; div_in = '0; div_valid = 1'b0;

    // Reset state
    tick_clk(); tick_clk();
    chk("rst_tick",  {31'd0, tick},      32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_ready", {31'd0, div_ready}, 32'd1);
`ifdef PARAM_PRESCALER_TICK_COUNT_EN
    chk("rst_total", tick_total, 32'd0);
`endif
    rst = 1'b0;
    tick_clk();

    // Continuous, D=4, then stop
    load_div(16'd4);
    exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12);
    start_pulse(1'b0, '0);
    run(1);
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    run(11);
    stop = 1'b1;
    run(6);
    chk("t1_busy_stop", {31'd0, busy}, 32'd0);
    chk("t1_sb_empty", exp_q.size(), 32'd0);

    // Burst of 5 at D=3
    load_div(16'd3);
    for (int k = 1; k <= 5; k++) exp_q.push_back(3 * k);
    start_pulse(1'b1, 4'd5);
    run(14);
    chk("t2_busy_c14", {31'd0, busy}, 32'd1);
    run(1);
    chk("t2_busy_c15", {31'd0, busy}, 32'd0);
    chk("t2_done_c15", {31'd0, done}, 32'd0);
    run(1);
    chk("t2_done_c16", {31'd0, done}, 32'd1);
    run(1);
    chk("t2_done_c17", {31'd0, done}, 32'd0);
    run(5);
    chk("t2_sb_empty", exp_q.size(), 32'd0);

    // burst_len=0 means 2^BURST_W ticks, D=1
    load_div(16'd1);
    for (int k = 1; k <= 16; k++) exp_q.push_back(k);
    start_pulse(1'b1, 4'd0);
    run(16);
    chk("b0_busy_c16", {31'd0, busy}, 32'd0);
    run(1);
    chk("b0_done_c17", {31'd0, done}, 32'd1);
    run(2);
    chk("b0_sb_empty", exp_q.size(), 32'd0);

    // div_in=0 stored as 1
    load_div(16'd0);
    for (int k = 1; k <= 8; k++) exp_q.push_back(k);
    start_pulse(1'b0, '0);
    run(8);
    stop = 1'b1;
    run(3);
    chk("t4_busy_stop", {31'd0, busy}, 32'd0);
    chk("t4_sb_empty", exp_q.size(), 32'd0);

    // start and stop together in IDLE: stop wins
    start_pulse(1'b0, '0);
    stop = 1'b1;
    run(5);
    chk("t5_busy_idle", {31'd0, busy}, 32'd0);

    // Stop mid-burst aborts without done
    load_div(16'd2);
    exp_q.push_back(2); exp_q.push_back(4);
    start_pulse(1'b1, 4'd5);
    run(5);
    stop = 1'b1;
    run(6);
    chk("t5_done_abort", {31'd0, done}, 32'd0);
    chk("t5_busy_abort", {31'd0, busy}, 32'd0);
    chk("t5_sb_empty", exp_q.size(), 32'd0);

    // Divisor change while running at D=10
    load_div(16'd10);
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(22);
    exp_q.push_back(24); exp_q.push_back(26);
    start_pulse(1'b0, '0);
    run(13);
    chk("t3_ready_c13", {31'd0, div_ready}, 32'd1);
    div_in    = 16'd2;
    div_valid = 1'b1;
    run(1);
    chk("t3_ready_c14", {31'd0, div_ready}, 32'd0);
    run(5);
    chk("t3_ready_c19", {31'd0, div_ready}, 32'd0);
    run(1);
    chk("t3_ready_c20", {31'd0, div_ready}, 32'd1);
    run(6);
    stop = 1'b1;
    run(4);
    chk("t3_sb_empty", exp_q.size(), 32'd0);

    // Async reset mid-run with a shadow divisor pending
    load_div(16'd5);
    exp_q.push_back(5); exp_q.push_back(10);
    start_pulse(1'b0, '0);
    run(7);
    div_in    = 16'd7;
    div_valid = 1'b1;
    run(1);
    chk("t6_ready_pend", {31'd0, div_ready}, 32'd0);
    run(2);
    chk("t6_sb_empty", exp_q.size(), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tick",  {31'd0, tick},      32'd0);
    chk("t6_rst_busy",  {31'd0, busy},      32'd0);
    chk("t6_rst_done",  {31'd0, done},      32'd0);
    chk("t6_rst_ready", {31'd0, div_ready}, 32'd1);
`ifdef PARAM_PRESCALER_TICK_COUNT_EN
    chk("t6_rst_total", tick_total, 32'd0);
`endif
    tick_clk();
    rst = 1'b0;
    tick_clk();

    // Divisor must be back at DEF_DIV
    exp_q.push_back(DEF_DIV);
    start_pulse(1'b0, '0);
    run(DEF_DIV);
    stop = 1'b1;
    run(2);
    chk("t6_def_div_empty", exp_q.size(), 32'd0);
`ifdef PARAM_PRESCALER_TICK_COUNT_EN
    chk("t6_total_after", tick_total, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
